// File: rtl/mpcache_pkg.sv
// ----------------------------------------------------------------------------
// mpcache_pkg
//   Definitions shared by the multiport cache blocks.
//   - sched_st_e : state encoding of the per-output-port queue scheduler
//                  (que_sched_ctrl).
//   - SCHED_PORTNUM_DEF / SCHED_TMO_CYC_DEF : default input-port count and
//                  default transfer timeout used by que_sched_ctrl.
// ----------------------------------------------------------------------------
package mpcache_pkg;

  localparam int SCHED_PORTNUM_DEF = 16;
  localparam int SCHED_TMO_CYC_DEF = 255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_UPD   = 3'd1,
    S_WAIT  = 3'd2,
    S_GRANT = 3'd3,
    S_XFER  = 3'd4,
    S_CLR   = 3'd5,
    S_DONE  = 3'd6
  } sched_st_e;

endpackage

// File: rtl/que_sched_ctrl.sv
// ----------------------------------------------------------------------------
// que_sched_ctrl
//   Sequencer between the per-output-port queue arbitrator and the read
//   engine. A round snapshots the arbitrator (o_arb_update), then for every
//   port the arbitrator selects: offer a grant to the read engine, wait for
//   the transfer to complete, clear the port in the arbitrator. The round
//   ends when a WAIT cycle sees no valid selection.
//
//   Optional feature: define QUE_SCHED_TMO_EN to enable the transfer
//   timeout. Without it o_tmo is tied low and XFER waits for i_done forever.
//
// Parameters
//   PORTNUM  number of input ports
//   TMO_CYC  XFER timeout in cycles (QUE_SCHED_TMO_EN only)
//
// Ports
//   i_clk, i_rst_n   clock, synchronous active-low reset
//   i_start          request a new round (only honoured in IDLE)
//   o_arb_update     one-cycle snapshot pulse to the arbitrator
//   i_arb_port       arbitrator selected port
//   i_arb_port_vld   selection valid (one cycle after update/clear)
//   i_arb_empty      arbitrator has nothing pending (informational)
//   o_arb_clr_port   port to clear in the arbitrator
//   o_arb_clr_vld    one-cycle clear pulse
//   o_grant_port     granted port
//   o_grant_vld      grant valid
//   i_grant_rdy      read engine accepts the grant
//   i_done           read engine finished the granted transfer
//   o_busy           round in progress
//   o_round_done     one-cycle end-of-round pulse
//   o_grant_cnt      grants issued in the current round (saturating)
//   o_tmo            one-cycle transfer-timeout pulse
//
// Grant handshake: o_grant_vld/o_grant_port come straight from the state and
// port registers, so once raised they stay high and unchanged until the cycle
// in which i_grant_rdy is also high; that single cycle is the transfer of the
// grant, after which the FSM moves to XFER and o_grant_vld drops.
//
// Every output is a decode of registers only (state, latched port, grant
// counter, timeout pulse register); no input reaches an output
// combinationally.
// ----------------------------------------------------------------------------
module que_sched_ctrl
  import mpcache_pkg::*;
#(
  parameter int PORTNUM = SCHED_PORTNUM_DEF,
  parameter int TMO_CYC = SCHED_TMO_CYC_DEF,
  localparam int PW = $clog2(PORTNUM),
  localparam int CW = $clog2(PORTNUM + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_arb_update,
  input  logic [PW-1:0] i_arb_port,
  input  logic          i_arb_port_vld,
  input  logic          i_arb_empty,
  output logic [PW-1:0] o_arb_clr_port,
  output logic          o_arb_clr_vld,
  output logic [PW-1:0] o_grant_port,
  output logic          o_grant_vld,
  input  logic          i_grant_rdy,
  input  logic          i_done,
  output logic          o_busy,
  output logic          o_round_done,
  output logic [CW-1:0] o_grant_cnt,
  output logic          o_tmo
);

  sched_st_e     state_q, state_d;
  logic [PW-1:0] port_q, port_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_hit;

  // i_arb_empty is redundant with i_arb_port_vld: an empty arbitrator simply
  // never raises valid, and a missing valid ends the round either way.
  logic unused_arb_empty;
  assign unused_arb_empty = i_arb_empty;

  // --------------------------------------------------------------------------
  // State, latched port and grant counter
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      port_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_UPD;
          cnt_d   = '0;
        end
      end
      S_UPD: begin
        state_d = S_WAIT;
      end
      // WAIT is always exactly one cycle: the arbitrator answers one cycle
      // after update/clear, and no valid there means nothing is left.
      S_WAIT: begin
        if (i_arb_port_vld) begin
          port_d  = i_arb_port;
          state_d = S_GRANT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_GRANT: begin
        if (i_grant_rdy) begin
          state_d = S_XFER;
          if (cnt_q != CW'(PORTNUM)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      // Completion is only sampled here; i_done in any other state is
      // ignored. A timeout abandons the port and clears it like a completion.
      S_XFER: begin
        if (i_done || tmo_hit) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_WAIT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Transfer timeout
  // --------------------------------------------------------------------------
`ifdef QUE_SCHED_TMO_EN
  localparam int TW = $clog2(TMO_CYC + 1);

  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_q;

  // The counter holds 0 in the first XFER cycle and k-1 in the k-th one. It
  // reaches TMO_CYC at the edge ending the TMO_CYC-th XFER cycle, so the
  // timeout decision is taken in that cycle. A coincident i_done wins.
  assign tmo_hit = (state_q == S_XFER) && !i_done &&
                   (tmo_cnt_q == TW'(TMO_CYC - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
      if (state_q == S_GRANT) begin
        tmo_cnt_q <= '0;
      end else if (state_q == S_XFER) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end

  // Registered, so the pulse coincides with the CLR of the abandoned port.
  assign o_tmo = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign o_tmo   = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Moore outputs
  // --------------------------------------------------------------------------
  assign o_arb_update   = (state_q == S_UPD);
  assign o_arb_clr_vld  = (state_q == S_CLR);
  assign o_arb_clr_port = port_q;
  assign o_grant_vld    = (state_q == S_GRANT);
  assign o_grant_port   = port_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_round_done   = (state_q == S_DONE);
  assign o_grant_cnt    = cnt_q;

endmodule

// File: tb/tb_que_sched_ctrl.sv
// ----------------------------------------------------------------------------
// tb_que_sched_ctrl
//   Directed bench for que_sched_ctrl. A small arbitrator model answers
//   update/clear pulses, a read-engine model answers grants with
//   configurable ready/done delays, and a scoreboard queue holds the grant
//   and clear order expected from each snapshot. Inputs change and outputs
//   are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_que_sched_ctrl;

  localparam int PN  = 16;
  localparam int TMO = 4;
  localparam int PW  = $clog2(PN);
  localparam int CW  = $clog2(PN + 1);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          start        = 1'b0;
  logic [PW-1:0] arb_port     = '0;
  logic          arb_port_vld = 1'b0;
  logic          arb_empty    = 1'b1;
  logic          grant_rdy    = 1'b0;
  logic          done         = 1'b0;
  logic          arb_update;
  logic [PW-1:0] arb_clr_port;
  logic          arb_clr_vld;
  logic [PW-1:0] grant_port;
  logic          grant_vld;
  logic          busy;
  logic          round_done;
  logic [CW-1:0] grant_cnt;
  logic          tmo;

  que_sched_ctrl #(.PORTNUM(PN), .TMO_CYC(TMO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .o_arb_update   (arb_update),
    .i_arb_port     (arb_port),
    .i_arb_port_vld (arb_port_vld),
    .i_arb_empty    (arb_empty),
    .o_arb_clr_port (arb_clr_port),
    .o_arb_clr_vld  (arb_clr_vld),
    .o_grant_port   (grant_port),
    .o_grant_vld    (grant_vld),
    .i_grant_rdy    (grant_rdy),
    .i_done         (done),
    .o_busy         (busy),
    .o_round_done   (round_done),
    .o_grant_cnt    (grant_cnt),
    .o_tmo          (tmo)
  );

  // ---------------- scoreboard / model state ----------------
  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [PW-1:0] exp_q[$];   // expected grant order
  logic [PW-1:0] clr_q[$];   // expected clear order
  logic [PW-1:0] arb_q[$];   // arbitrator model pending list
  logic [PW-1:0] pend[$];    // contents of the next snapshot

  int rdy_delay     = 0;
  int done_delay    = 0;
  bit done_in_grant = 0;
  bit start_in_xfer = 0;
  bit start_in_done = 0;

  bit            upd_clr_prev = 0;
  bit            in_grant     = 0;
  bit            in_xfer      = 0;
  bit            done_given   = 0;
  int            gwait        = 0;
  int            xcnt         = 0;
  logic [PW-1:0] held_port    = '0;

  int n_upd, n_gvld, n_clr, n_tmo, n_done_pulse, n_grant;
  int upd_cyc, done_cyc, t0;
  logic [CW-1:0] cnt_at_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [18:0] all_outs();
    return {arb_update, arb_clr_port, arb_clr_vld, grant_port, grant_vld,
            busy, round_done, grant_cnt, tmo};
  endfunction

  task automatic reset_model();
    exp_q.delete(); clr_q.delete(); arb_q.delete();
    upd_clr_prev = 0; in_grant = 0; in_xfer = 0; done_given = 0;
    gwait = 0; xcnt = 0;
  endtask

  // One clock: wait for the falling edge, observe outputs, drive inputs for
  // the next rising edge.
  task automatic step();
    bit was_upd_clr;
    @(negedge clk);
    cyc++;
    start        = 1'b0;
    arb_port_vld = 1'b0;
    grant_rdy    = 1'b0;
    done         = 1'b0;

    // Arbitrator answers in the cycle after an update or clear.
    if (upd_clr_prev && arb_q.size() > 0) begin
      arb_port_vld = 1'b1;
      arb_port     = arb_q[0];
    end
    was_upd_clr = arb_update | arb_clr_vld;

    if (arb_update) begin
      n_upd++;
      upd_cyc = cyc;
      arb_q   = pend;
      foreach (pend[i]) begin
        exp_q.push_back(pend[i]);
        clr_q.push_back(pend[i]);
      end
    end

    if (arb_clr_vld) begin
      n_clr++;
      if (clr_q.size() == 0) check("clr_unexpected", arb_clr_vld, 0);
      else check("clr_port", arb_clr_port, clr_q.pop_front());
      check("clr_cause", done_given | tmo, 1);
`ifdef QUE_SCHED_TMO_EN
      if (tmo) check("tmo_xfer_cycles", xcnt, TMO);
`endif
      if (arb_q.size() > 0) void'(arb_q.pop_front());
      in_xfer    = 0;
      done_given = 0;
    end

    if (tmo) n_tmo++;
    if (round_done) begin
      n_done_pulse++;
      done_cyc    = cyc;
      cnt_at_done = grant_cnt;
      if (start_in_done) start = 1'b1;
    end

    if (grant_vld) begin
      n_gvld++;
      if (!in_grant) begin
        in_grant  = 1;
        gwait     = 0;
        held_port = grant_port;
      end else begin
        check("grant_port_stable", grant_port, held_port);
      end
      if (done_in_grant) done = 1'b1;
      if (gwait >= rdy_delay) begin
        grant_rdy = 1'b1;
        check("grant_cnt_before", grant_cnt, (n_grant < PN) ? n_grant : PN);
        n_grant++;
        if (exp_q.size() == 0) check("grant_unexpected", grant_vld, 0);
        else check("grant_port", grant_port, exp_q.pop_front());
        in_grant   = 0;
        in_xfer    = 1;
        xcnt       = 0;
        done_given = 0;
      end else begin
        gwait++;
      end
    end else if (in_xfer) begin
      xcnt++;
      if (start_in_xfer) start = 1'b1;
      if (xcnt > done_delay) begin
        done       = 1'b1;
        done_given = 1;
        in_xfer    = 0;
      end
    end

    upd_clr_prev = was_upd_clr;
    arb_empty    = (arb_q.size() == 0);
  endtask

  // Start a round from IDLE and run it to its DONE cycle (bounded).
  task automatic run_round(input string tag, input int max_cyc);
    n_upd = 0; n_gvld = 0; n_clr = 0; n_tmo = 0; n_done_pulse = 0; n_grant = 0;
    upd_cyc = -1; done_cyc = -1;
    step();
    check({tag, "_idle_before"}, busy, 0);
    start = 1'b1;
    t0    = cyc;
    for (int i = 0; i < max_cyc && n_done_pulse == 0; i++) step();
    check({tag, "_round_finished"}, n_done_pulse, 1);
    check({tag, "_upd_latency"}, upd_cyc - t0, 1);
    check({tag, "_upd_count"}, n_upd, 1);
  endtask

  // Global safety net.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset defaults ----
    for (int i = 0; i < 3; i++) step();
    check("por_outputs", all_outs(), 0);
    rst_n = 1'b1;

    // ---- reset in the middle of a GRANT ----
    pend = {4'd4};
    rdy_delay = 1000;
    step();
    start = 1'b1;
    for (int i = 0; i < 10 && !grant_vld; i++) step();
    check("reached_grant", grant_vld, 1);
    rst_n = 1'b0;
    step();
    check("rst_mid_grant_1", all_outs(), 0);
    step();
    step();
    check("rst_mid_grant_3", all_outs(), 0);
    reset_model();
    rst_n = 1'b1;
    rdy_delay = 0;

    // ---- empty snapshot (also checks update in cycle 1 after reset) ----
    pend.delete();
    run_round("empty", 20);
    check("empty_done_after_upd", done_cyc - upd_cyc, 2);
    check("empty_grant_cnt", cnt_at_done, 0);
    check("empty_no_grant", n_gvld, 0);

    // ---- three ports, immediate ready/done ----
    pend = {4'd3, 4'd7, 4'd12};
    rdy_delay = 0; done_delay = 0;
    run_round("three", 60);
    check("three_grant_cnt", cnt_at_done, 3);
    check("three_clears", n_clr, 3);
    check("three_round_len", done_cyc - t0 + 1, 16);
    check("three_all_granted", exp_q.size(), 0);

    // ---- backpressure: ready low 5 cycles ----
    pend = {4'd5};
    rdy_delay = 5; done_delay = 2;
    run_round("bp", 60);
    check("bp_vld_cycles", n_gvld, 6);
    check("bp_grant_cnt", cnt_at_done, 1);
    rdy_delay = 0; done_delay = 0;

    // ---- ignored events: start in XFER/DONE, done in GRANT ----
    pend = {4'd2, 4'd9};
    rdy_delay = 2; done_delay = 3;
    done_in_grant = 1; start_in_xfer = 1; start_in_done = 1;
    run_round("ign", 80);
    done_in_grant = 0; start_in_xfer = 0; start_in_done = 0;
    check("ign_clears", n_clr, 2);
    check("ign_grant_cnt", cnt_at_done, 2);
    step();
    check("ign_idle_after_done", busy, 0);
    step();
    step();
    check("ign_no_extra_update", n_upd, 1);
    check("ign_still_idle", busy, 0);
    rdy_delay = 0; done_delay = 0;

    // ---- grant counter saturation ----
    pend.delete();
    for (int i = 0; i < PN + 1; i++) pend.push_back(PW'(i));
    run_round("sat", 200);
    check("sat_grant_cnt", cnt_at_done, PN);
    check("sat_grants_seen", n_grant, PN + 1);

`ifdef QUE_SCHED_TMO_EN
    // ---- timeout: no completion at all ----
    pend = {4'd1, 4'd6};
    done_delay = 1000;
    run_round("tmo", 80);
    check("tmo_pulses", n_tmo, 2);
    check("tmo_clears", n_clr, 2);
    check("tmo_grant_cnt", cnt_at_done, 2);

    // ---- completion on the terminal-count cycle wins ----
    pend = {4'd10};
    done_delay = TMO - 1;
    run_round("tmo_tie", 40);
    check("tmo_tie_no_pulse", n_tmo, 0);
    check("tmo_tie_clears", n_clr, 1);
    done_delay = 0;
`else
    // ---- timeout disabled: long transfer, no timeout pulse ----
    pend = {4'd1};
    done_delay = 3 * TMO;
    run_round("notmo", 60);
    check("notmo_no_pulse", n_tmo, 0);
    check("notmo_clears", n_clr, 1);
    done_delay = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/que_sched_ctrl.md
# que_sched_ctrl

Sequencer for the per-output-port queue arbitrator. It starts a scheduling round by snapshotting pending/priority state into the arbitrator, then for each selected input port:

- offers the grant to the read engine over a valid/ready handshake,
- waits for transfer completion,
- clears that port in the arbitrator,

and repeats until the arbitrator reports empty. It sits between the arbitrator and the read engine of each output port in the multiport cache.

## Interface
Parameters:
- PORTNUM, 16, number of input ports
- TMO_CYC, 255, XFER timeout in cycles (used only with QUE_SCHED_TMO_EN)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_start  in  1  request a new round; sampled only in IDLE
- o_arb_update  out  1  one-cycle snapshot pulse to arbitrator
- i_arb_port  in  $clog2(PORTNUM)  arbitrator selected port
- i_arb_port_vld  in  1  arbitrator selection valid (one cycle after update/clear)
- i_arb_empty  in  1  arbitrator has no pending port
- o_arb_clr_port  out  $clog2(PORTNUM)  port to clear
- o_arb_clr_vld  out  1  one-cycle clear pulse
- o_grant_port  out  $clog2(PORTNUM)  granted port
- o_grant_vld  out  1  grant valid
- i_grant_rdy  in  1  read engine accepts grant
- i_done  in  1  read engine finished granted transfer
- o_busy  out  1  round in progress (state != IDLE)
- o_round_done  out  1  one-cycle end-of-round pulse
- o_grant_cnt  out  $clog2(PORTNUM+1)  grants issued in current round
- o_tmo  out  1  one-cycle timeout pulse (0 when macro absent)

## Operation
- Moore FSM. All outputs decode from the state register, the latched port register and the grant counter. No input-to-output combinational path.
- States: IDLE, UPD, WAIT, GRANT, XFER, CLR, DONE.
- IDLE: i_start=1 -> UPD, clear o_grant_cnt.
- UPD: o_arb_update=1 -> WAIT.
- WAIT lasts exactly one cycle:
  - i_arb_port_vld=1: latch i_arb_port -> GRANT.
  - Otherwise -> DONE (covers i_arb_empty and spurious no-valid).
- GRANT: o_grant_vld=1, o_grant_port = latched port, held stable until i_grant_rdy=1. The handshake cycle increments o_grant_cnt -> XFER.
- XFER: i_done=1 -> CLR.
- CLR: o_arb_clr_vld=1, o_arb_clr_port = latched port -> WAIT.
- DONE: o_round_done=1 -> IDLE.
- Boundary conditions:
  - i_start while busy: ignored, not queued.
  - i_start in the DONE cycle: ignored; a new round needs i_start while in IDLE.
  - i_done outside XFER: ignored.
  - i_done asserted in the GRANT handshake cycle: ignored; completion is only sampled in XFER.
  - o_grant_cnt saturates at PORTNUM.
  - Empty snapshot: UPD -> WAIT -> DONE, o_grant_cnt=0.
- Reset, including mid-round: at the next edge with i_rst_n=0, state=IDLE and latched port=0, o_grant_cnt=0, timeout counter=0.
  - The arbitrator is reset by the parent on the same reset; this block issues no clear on reset.
- Reset values: all outputs 0.

## Timing
- i_start high in cycle 0:
  - o_arb_update high in cycle 1.
  - WAIT in cycle 2.
  - o_grant_vld first high in cycle 3.
- Grant accepted in cycle g -> XFER from g+1.
- i_done in cycle d -> o_arb_clr_vld in d+1 -> WAIT in d+2 -> next o_grant_vld in d+3, or o_round_done in d+3.
- Per-grant overhead excluding transfer and ready wait: 3 cycles.
- Minimum round with N grants (rdy and done immediate): 3 + 4N + 1 cycles, including DONE.

## Configuration
- QUE_SCHED_TMO_EN defined:
  - A $clog2(TMO_CYC+1)-bit counter clears on XFER entry and increments each XFER cycle.
  - When the counter reaches TMO_CYC with i_done=0: o_tmo pulses for one cycle and the FSM goes to CLR (port abandoned and cleared).
  - i_done in the same cycle as the terminal count wins: no o_tmo.
- QUE_SCHED_TMO_EN undefined: no counter, o_tmo tied 0, XFER waits indefinitely.

## Structure
- Shared package mpcache_pkg: typedef enum sched_st_e (the seven states), localparam defaults for PORTNUM and TMO_CYC.
- No sub-module. The timeout counter is inline, under the macro.
- The arbitrator is a sibling instance wired by the parent.

## Test plan
- Reset defaults: hold reset 3 cycles, mid-GRANT -> all outputs 0, FSM back in IDLE one edge after reset; i_start then yields o_arb_update in cycle 1.
- Empty round: i_start with arbitrator empty -> o_arb_update, then o_round_done 2 cycles later, o_grant_cnt=0, no o_grant_vld.
- Three ports (3, 7, 12) pending, rdy/done immediate:
  - Grants arrive in arbitrator order.
  - Each clear carries the matching port.
  - o_grant_cnt=3 at DONE.
  - Round lasts 16 cycles.
- Backpressure: i_grant_rdy low 5 cycles -> o_grant_vld and o_grant_port stable for all 6 cycles, o_grant_cnt increments once.
- Ignored events: i_start during XFER, and i_done during GRANT -> no extra update pulse, no premature clear.
- QUE_SCHED_TMO_EN with TMO_CYC=4:
  - No i_done -> o_tmo pulse after 4 XFER cycles, clear of the stalled port, round continues.
  - i_done coincident with terminal count -> no o_tmo.
